// File: rtl/systolic_seq.sv
// Control sequencer for one DIM x DIM systolic matrix multiply.
// Walks clear, load, compute/drain and result readout; carries no datapath, only strobes and row indices.
module systolic_seq #(
  parameter int DIM   = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             ld_en,
  output logic [CNT_W-1:0] ld_row,
  output logic             sa_clr,
  output logic             sk_en,
  output logic             feed_valid,
  output logic [CNT_W-1:0] feed_row,
  output logic             c_valid,
  output logic [CNT_W-1:0] c_row,
  input  logic             c_ready,
  output logic             busy,
  output logic             done
);

  // state     | meaning
  // S_IDLE    | waiting for start, all strobes low
  // S_CLEAR   | one-cycle accumulator clear
  // S_LOAD    | write DIM rows into the A/B row buffers
  // S_COMPUTE | DIM feed cycles, then 2*DIM-2 drain cycles
  // S_READ    | offer result rows 0..DIM-1 with ready/valid
  // S_FIN     | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_READ,
    S_FIN
  } state_t;

  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] FEED_END  = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(3 * DIM - 3);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             feed_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (cnt_q == ROW_LAST) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == COMP_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_READ: begin
        // the row index only moves on an accepted transfer
        if (c_valid && c_ready) begin
          if (cnt_q == ROW_LAST) begin
            state_d = S_FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign feed_d = (state_d == S_COMPUTE) && (cnt_d < FEED_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_en      <= 1'b0;
      ld_row     <= '0;
      sa_clr     <= 1'b0;
      sk_en      <= 1'b0;
      feed_valid <= 1'b0;
      feed_row   <= '0;
      c_valid    <= 1'b0;
      c_row      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ld_en      <= (state_d == S_LOAD);
      ld_row     <= (state_d == S_LOAD) ? cnt_d : '0;
      sa_clr     <= (state_d == S_CLEAR);
      sk_en      <= (state_d == S_COMPUTE);
      feed_valid <= feed_d;
      feed_row   <= feed_d ? cnt_d : '0;
      c_valid    <= (state_d == S_READ);
      c_row      <= (state_d == S_READ) ? cnt_d : '0;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_FIN);
    end
  end

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq: cycle-exact strobe windows plus a result-row / done scoreboard.
// Cycle k is the clock period ending at edge k; inputs driven in cycle k are sampled at that edge.
module tb_systolic_seq;
  localparam int DIM   = 8;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst, start, abort, c_ready;
  logic             ld_en, sa_clr, sk_en, feed_valid, c_valid, busy, done;
  logic [CNT_W-1:0] ld_row, feed_row, c_row;

  int n_checks = 0;
  int n_errors = 0;
  int exp_rows[$];
  int exp_done[$];

  systolic_seq #(.DIM(DIM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .ld_en(ld_en), .ld_row(ld_row), .sa_clr(sa_clr), .sk_en(sk_en),
    .feed_valid(feed_valid), .feed_row(feed_row),
    .c_valid(c_valid), .c_row(c_row), .c_ready(c_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, obs, exp);
    end
  endtask

  // s: start cycle, s2: extra start, ab: abort cycle, rs: reset cycle,
  // lo_a..lo_b: c_ready low, d: expected done cycle (-1 none), ncyc: cycles checked
  task automatic run(input string name, input int s, input int s2, input int ab, input int rs,
                     input int lo_a, input int lo_b, input int d, input int ncyc);
    int   cut;
    int   end_c;
    logic pv;
    logic pr;
    int   prow;
    cut = 1 << 30;
    if (ab >= 0 && ab > s) cut = ab + 1;
    if (rs >= 0 && rs + 1 < cut) cut = rs + 1;
    end_c = (d >= 0) ? d : cut - 1;
    pv = 1'b0; pr = 1'b1; prow = 0;
    for (int k = 0; k < ncyc; k++) begin
      int r;
      bit live;
      bit ld_x, sk_x, fv_x;
      r    = k - s;
      live = (s >= 0) && (k > s) && (k <= end_c) && (k < cut);
      ld_x = live && r >= 2 && r < 2 + DIM;
      sk_x = live && r >= 2 + DIM && r < 4 * DIM;
      fv_x = live && r >= 2 + DIM && r < 2 + 2 * DIM;
      chk({name, ":sa_clr"}, int'(sa_clr), int'(live && r == 1));
      chk({name, ":ld_en"}, int'(ld_en), int'(ld_x));
      if (ld_x) chk({name, ":ld_row"}, int'(ld_row), r - 2);
      chk({name, ":sk_en"}, int'(sk_en), int'(sk_x));
      chk({name, ":feed_valid"}, int'(feed_valid), int'(fv_x));
      if (fv_x) chk({name, ":feed_row"}, int'(feed_row), r - 2 - DIM);
      chk({name, ":c_valid"}, int'(c_valid), int'(live && r >= 4 * DIM && k != d));
      chk({name, ":busy"}, int'(busy), int'(live));
      chk({name, ":done"}, int'(done), int'(live && k == d));
      if (pv && !pr) begin
        chk({name, ":hold_valid"}, int'(c_valid), 1);
        chk({name, ":hold_row"}, int'(c_row), prow);
      end

      start   = (k == s) || (k == s2);
      abort   = (k == ab);
      rst     = (k == rs);
      c_ready = !(k >= lo_a && k <= lo_b);
      if (k == s) begin
        for (int i = 0; i < DIM; i++) exp_rows.push_back(i);
        if (d >= 0) exp_done.push_back(d);
      end

      if (c_valid && c_ready) begin
        if (exp_rows.size() > 0) chk({name, ":c_row"}, int'(c_row), exp_rows.pop_front());
        else chk({name, ":row_extra"}, 1, 0);
      end
      if (done) begin
        if (exp_done.size() > 0) chk({name, ":done_cyc"}, k, exp_done.pop_front());
        else chk({name, ":done_extra"}, 1, 0);
      end
      if ((abort && ab > s) || rst) begin
        exp_rows.delete();
        exp_done.delete();
      end
      pv = c_valid; pr = c_ready; prow = int'(c_row);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; c_ready = 1'b1;
    chk({name, ":rows_left"}, exp_rows.size(), 0);
    chk({name, ":done_left"}, exp_done.size(), 0);
    exp_rows.delete();
    exp_done.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; c_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst:busy", int'(busy), 0);
    chk("rst:done", int'(done), 0);
    chk("rst:sa_clr", int'(sa_clr), 0);
    chk("rst:ld_en", int'(ld_en), 0);
    chk("rst:sk_en", int'(sk_en), 0);
    chk("rst:c_valid", int'(c_valid), 0);
    chk("rst:rows", int'(ld_row) + int'(feed_row) + int'(c_row), 0);
    rst = 1'b0; start = 1'b0;

    run("idle",        -1, -1, -1, -1, -1, -1, -1, 5);
    run("abort_idle",  -1, -1,  2, -1, -1, -1, -1, 5);
    run("nominal",      0, -1, -1, -1, -1, -1, 40, 42);
    run("backpress",    0, -1, -1, -1, 33, 35, 43, 45);
    run("start_busy",   0, 15, -1, -1, -1, -1, 40, 42);
    run("abort_comp",   0, -1, 20, -1, -1, -1, -1, 22);
    run("after_abort",  0, -1, -1, -1, -1, -1, 40, 42);
    run("reset_read",   0, -1, -1, 35, -1, -1, -1, 37);
    run("after_reset",  0, -1, -1, -1, -1, -1, 40, 42);
    run("abort_fin",    0, -1, 40, -1, -1, -1, 40, 43);
    run("start_abort",  0, -1,  0, -1, -1, -1, 40, 42);
    run("bp_first",     0, -1, -1, -1, 31, 33, 42, 44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1);
  end

endmodule
